// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types for the L1-to-L2 arbiter: address mux select, grant memory and FSM encoding.
package arbiteraddressmux;

   typedef enum logic {
      i_addr = 1'b0,
      d_addr = 1'b1
   } arbiteraddressmux_sel_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SERVE_I = 2'd1;
   localparam logic [1:0] ST_SERVE_D = 2'd2;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

endpackage

// File: rtl/l1_mem_arbiter_control.sv
// Grant FSM with two-way round-robin memory; drives L2 strobes and per-cache completion pulses.
module arbiter_control
   import arbiteraddressmux::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_i_read,
   input  logic                   i_d_read,
   input  logic                   i_d_write,
   input  logic                   i_l2_resp,
   output arbiteraddressmux_sel_t o_addr_sel,
   output logic                   o_l2_read,
   output logic                   o_l2_write,
   output logic                   o_i_resp,
   output logic                   o_d_resp
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   grant_t     r_last_grant;
   logic       w_i_req;
   logic       w_d_req;

   assign w_i_req = i_i_read;
   assign w_d_req = i_d_read | i_d_write;

   // Leaving a SERVE state on either completion or the requester withdrawing.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_i_req && w_d_req)
               w_state_nxt = (r_last_grant == GRANT_D) ? ST_SERVE_I : ST_SERVE_D;
            else if (w_d_req)
               w_state_nxt = ST_SERVE_D;
            else if (w_i_req)
               w_state_nxt = ST_SERVE_I;
         end
         ST_SERVE_I: if (i_l2_resp || !w_i_req) w_state_nxt = ST_IDLE;
         ST_SERVE_D: if (i_l2_resp || !w_d_req) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GRANT_I;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_state_nxt == ST_SERVE_I)
            r_last_grant <= GRANT_I;
         else if (r_state == ST_IDLE && w_state_nxt == ST_SERVE_D)
            r_last_grant <= GRANT_D;
      end
   end

   always_comb begin
      o_addr_sel = i_addr;
      o_l2_read  = 1'b0;
      o_l2_write = 1'b0;
      o_i_resp   = 1'b0;
      o_d_resp   = 1'b0;
      case (r_state)
         ST_SERVE_I: begin
            o_l2_read = i_i_read;
            o_i_resp  = i_l2_resp;
         end
         ST_SERVE_D: begin
            o_addr_sel = d_addr;
            o_l2_read  = i_d_read;
            o_l2_write = i_d_write;
            o_d_resp   = i_l2_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l1_mem_arbiter_datapath.sv
// Combinational routing between the two L1 ports and the single L2 port.
module arbiter_datapath
   import arbiteraddressmux::*;
(
   input  arbiteraddressmux_sel_t i_addr_sel,
   input  logic [ADDR_W-1:0]      i_i_address,
   input  logic [ADDR_W-1:0]      i_d_address,
   input  logic [LINE_W-1:0]      i_d_wdata,
   input  logic [LINE_W-1:0]      i_l2_rdata,
   output logic [ADDR_W-1:0]      o_l2_address,
   output logic [LINE_W-1:0]      o_l2_wdata,
   output logic [LINE_W-1:0]      o_i_rdata,
   output logic [LINE_W-1:0]      o_d_rdata
);

   assign o_l2_address = (i_addr_sel == d_addr) ? i_d_address : i_i_address;
   assign o_l2_wdata   = i_d_wdata;
   // Read data fans out to both caches; each is qualified only by its own resp.
   assign o_i_rdata    = i_l2_rdata;
   assign o_d_rdata    = i_l2_rdata;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbitrates the split L1 I/D caches onto the single L2 request port.
module l1_mem_arbiter
   import arbiteraddressmux::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   i_pmem_address,
   input  logic          i_pmem_read,
   output logic [255:0]  i_pmem_rdata,
   output logic          i_pmem_resp,
   input  logic [31:0]   d_pmem_address,
   input  logic          d_pmem_read,
   input  logic          d_pmem_write,
   input  logic [255:0]  d_pmem_wdata,
   output logic [255:0]  d_pmem_rdata,
   output logic          d_pmem_resp,
   output logic [31:0]   a_pmem_address,
   output logic          a_pmem_read,
   output logic          a_pmem_write,
   output logic [255:0]  a_pmem_wdata,
   input  logic [255:0]  a_pmem_rdata,
   input  logic          a_pmem_resp
);

   arbiteraddressmux_sel_t w_addr_sel;

   arbiter_control u_control (
      .clk        (clk),
      .rst        (rst),
      .i_i_read   (i_pmem_read),
      .i_d_read   (d_pmem_read),
      .i_d_write  (d_pmem_write),
      .i_l2_resp  (a_pmem_resp),
      .o_addr_sel (w_addr_sel),
      .o_l2_read  (a_pmem_read),
      .o_l2_write (a_pmem_write),
      .o_i_resp   (i_pmem_resp),
      .o_d_resp   (d_pmem_resp)
   );

   arbiter_datapath u_datapath (
      .i_addr_sel   (w_addr_sel),
      .i_i_address  (i_pmem_address),
      .i_d_address  (d_pmem_address),
      .i_d_wdata    (d_pmem_wdata),
      .i_l2_rdata   (a_pmem_rdata),
      .o_l2_address (a_pmem_address),
      .o_l2_wdata   (a_pmem_wdata),
      .o_i_rdata    (i_pmem_rdata),
      .o_d_rdata    (d_pmem_rdata)
   );

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed plus randomized bench for l1_mem_arbiter against an ownership-based reference model.
module tb_l1_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_pmem_address;
   logic         i_pmem_read;
   logic [255:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic [31:0]  d_pmem_address;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [255:0] d_pmem_wdata;
   logic [255:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic [31:0]  a_pmem_address;
   logic         a_pmem_read;
   logic         a_pmem_write;
   logic [255:0] a_pmem_wdata;
   logic [255:0] a_pmem_rdata;
   logic         a_pmem_resp;

   l1_mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .a_pmem_address (a_pmem_address),
      .a_pmem_read    (a_pmem_read),
      .a_pmem_write   (a_pmem_write),
      .a_pmem_wdata   (a_pmem_wdata),
      .a_pmem_rdata   (a_pmem_rdata),
      .a_pmem_resp    (a_pmem_resp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: which cache currently owns L2 (0 none, 1 I, 2 D) and who won the last grant.
   int m_owner  = 0;
   bit m_last_d = 1'b0;
   bit i_done   = 1'b0;
   bit d_done   = 1'b0;
   int obs_q[$];
   int exp_q[$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      return $urandom & 32'hffff_ffe0;
   endfunction

   task automatic clear_inputs();
      i_pmem_address = '0; i_pmem_read = 1'b0;
      d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
      a_pmem_rdata = '0; a_pmem_resp = 1'b0;
   endtask

   // Called near a negedge with inputs set: checks outputs, then advances model and clock.
   task automatic step();
      logic [31:0] e_addr;
      logic        e_read, e_write, e_iresp, e_dresp;
      #1;
      e_addr  = (m_owner == 2) ? d_pmem_address : i_pmem_address;
      e_read  = (m_owner == 1) ? i_pmem_read : (m_owner == 2) ? d_pmem_read : 1'b0;
      e_write = (m_owner == 2) ? d_pmem_write : 1'b0;
      e_iresp = (m_owner == 1) && a_pmem_resp;
      e_dresp = (m_owner == 2) && a_pmem_resp;
      check("a_addr",  {224'd0, a_pmem_address}, {224'd0, e_addr});
      check("a_read",  {255'd0, a_pmem_read},    {255'd0, e_read});
      check("a_write", {255'd0, a_pmem_write},   {255'd0, e_write});
      check("i_resp",  {255'd0, i_pmem_resp},    {255'd0, e_iresp});
      check("d_resp",  {255'd0, d_pmem_resp},    {255'd0, e_dresp});
      check("a_wdata", a_pmem_wdata, d_pmem_wdata);
      check("i_rdata", i_pmem_rdata, a_pmem_rdata);
      check("d_rdata", d_pmem_rdata, a_pmem_rdata);
      if (i_pmem_resp === 1'b1) obs_q.push_back(1);
      if (d_pmem_resp === 1'b1) obs_q.push_back(2);
      i_done = e_iresp;
      d_done = e_dresp;
      @(posedge clk);
      if (m_owner == 0) begin
         if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_owner = m_last_d ? 1 : 2;
         else if (d_pmem_read || d_pmem_write)             m_owner = 2;
         else if (i_pmem_read)                             m_owner = 1;
         if (m_owner != 0) m_last_d = (m_owner == 2);
      end else if (m_owner == 1) begin
         if (a_pmem_resp || !i_pmem_read) m_owner = 0;
      end else begin
         if (a_pmem_resp || !(d_pmem_read || d_pmem_write)) m_owner = 0;
      end
      @(negedge clk);
   endtask

   // Asserts reset with requests and an L2 resp present; everything must drop at once.
   task automatic do_reset();
      i_pmem_read = 1'b1;
      d_pmem_write = 1'b1;
      a_pmem_resp = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_a_read",  {255'd0, a_pmem_read},  256'd0);
      check("rst_a_write", {255'd0, a_pmem_write}, 256'd0);
      check("rst_i_resp",  {255'd0, i_pmem_resp},  256'd0);
      check("rst_d_resp",  {255'd0, d_pmem_resp},  256'd0);
      repeat (2) @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      m_owner = 0;
      m_last_d = 1'b0;
   endtask

   initial begin
      logic [255:0] pat;
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      do_reset();

      // I-only read, L2 responds at cycle 4.
      pat = rand_line();
      i_pmem_address = 32'h0000_0060;
      for (int c = 0; c < 6; c++) begin
         i_pmem_read = (c < 5);
         a_pmem_resp = (c == 4);
         a_pmem_rdata = pat;
         #1;
         check("ionly_read", {255'd0, a_pmem_read}, {255'd0, (c >= 1 && c <= 4)});
         check("ionly_iresp", {255'd0, i_pmem_resp}, {255'd0, (c == 4)});
         if (c == 4) check("ionly_rdata", i_pmem_rdata, pat);
         step();
      end

      // D write-back, L2 responds at cycle 3.
      pat = rand_line();
      d_pmem_address = 32'h0000_1000;
      d_pmem_wdata = pat;
      for (int c = 0; c < 5; c++) begin
         d_pmem_write = (c < 4);
         a_pmem_resp = (c == 3);
         #1;
         check("dwb_write", {255'd0, a_pmem_write}, {255'd0, (c >= 1 && c <= 3)});
         check("dwb_dresp", {255'd0, d_pmem_resp}, {255'd0, (c == 3)});
         if (c == 1) check("dwb_addr", {224'd0, a_pmem_address}, {224'd0, 32'h0000_1000});
         if (c == 1) check("dwb_wdata", a_pmem_wdata, pat);
         step();
      end

      // Simultaneous requests from reset: D first, dead cycle, then I.
      do_reset();
      i_pmem_address = 32'h0000_2000;
      d_pmem_address = 32'h0000_3000;
      for (int c = 0; c < 7; c++) begin
         d_pmem_read = (c < 3);
         i_pmem_read = (c < 6);
         a_pmem_resp = (c == 2 || c == 5);
         #1;
         check("sim_addr", {224'd0, a_pmem_address},
               {224'd0, (c == 1 || c == 2) ? 32'h0000_3000 : 32'h0000_2000});
         check("sim_dresp", {255'd0, d_pmem_resp}, {255'd0, (c == 2)});
         check("sim_iresp", {255'd0, i_pmem_resp}, {255'd0, (c == 5)});
         step();
      end

      // Continuous contention: completions must alternate D, I, D, I.
      do_reset();
      obs_q.delete();
      exp_q = '{2, 1, 2, 1};
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
      for (int c = 0; c < 12; c++) begin
         a_pmem_resp = (c % 3 == 2);
         step();
      end
      check("rr_count", 256'(obs_q.size()), 256'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         check("rr_order", 256'(obs_q[k]), 256'(exp_q[k]));
      clear_inputs();
      step();

      // Reset while D is being served.
      d_pmem_address = 32'h0000_4000;
      d_pmem_write = 1'b1;
      step();
      step();
      #1;
      check("mid_write_pre", {255'd0, a_pmem_write}, 256'd1);
      do_reset();

      // Spurious L2 resp while idle.
      for (int c = 0; c < 3; c++) begin
         a_pmem_resp = 1'b1;
         a_pmem_rdata = rand_line();
         #1;
         check("spur_iresp", {255'd0, i_pmem_resp}, 256'd0);
         check("spur_dresp", {255'd0, d_pmem_resp}, 256'd0);
         step();
      end
      clear_inputs();

      // Randomized traffic with holds, aborts and random L2 latency.
      for (int n = 0; n < 1500; n++) begin
         if (i_pmem_read) begin
            if (i_done) begin
               i_pmem_read = 1'($urandom_range(0, 1));
               i_pmem_address = rand_addr();
            end else if ($urandom_range(0, 40) == 0) begin
               i_pmem_read = 1'b0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            i_pmem_read = 1'b1;
            i_pmem_address = rand_addr();
         end
         if (d_pmem_read || d_pmem_write) begin
            if (d_done || $urandom_range(0, 40) == 0) begin
               d_pmem_read = 1'b0;
               d_pmem_write = 1'b0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) d_pmem_read = 1'b1;
            else d_pmem_write = 1'b1;
            d_pmem_address = rand_addr();
            d_pmem_wdata = rand_line();
         end
         a_pmem_resp = ($urandom_range(0, 2) == 0);
         a_pmem_rdata = rand_line();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
